// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a show-ahead receive FIFO.
//   The serial line passes through a 2-flop synchroniser. Each bit is sampled at its
//   centre. Configurable data width and parity (none/odd/even). Accepted words are
//   pushed into a FIFO that the consumer drains through a valid/ready port.
//   Framing, parity and overrun errors are reported as sticky flags.
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   ser_rx      asynchronous serial input, idles high
//   rx_data     FIFO head word (zero while empty)
//   rx_valid    FIFO not empty
//   rx_ready    consumer pops the head when rx_valid && rx_ready
//   fifo_count  current FIFO occupancy, 0..FIFO_DEPTH
//   frame_err   sticky: stop bit sampled low
//   parity_err  sticky: parity mismatch
//   overrun     sticky: word arrived while FIFO full
//   clr_err     clears all sticky flags (a same-cycle set wins)
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ser_rx,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          clr_err
);

    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned CW   = $clog2(CLK_DIV);

    localparam logic [CW-1:0]   HalfLoad = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]   FullLoad = CW'(CLK_DIV - 1);
    localparam logic [3:0]      LastBit  = 4'(DATA_BITS - 1);
    localparam logic [CNTW-1:0] FullCnt  = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    // Synchroniser and edge detection
    logic       r_sync1, r_sync2;
    logic [1:0] r_live;
    logic       r_prev_hi;
    logic       w_rx_s;
    logic       w_fall;

    assign w_rx_s = r_sync2;
    // r_prev_hi only counts a high level that came from the pad, not the synchroniser's
    // reset value, so a line that is already low at reset release never looks like an edge.
    assign w_fall = r_prev_hi & ~w_rx_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_live    <= 2'b00;
            r_prev_hi <= 1'b0;
        end else begin
            r_sync1   <= ser_rx;
            r_sync2   <= r_sync1;
            r_live    <= {r_live[0], 1'b1};
            r_prev_hi <= r_live[1] & w_rx_s;
        end
    end

    // Receive FSM
    state_e               r_state, w_state_next;
    logic [CW-1:0]        r_div, w_div_next;
    logic [3:0]           r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_par, w_par_next;
    logic                 w_stop_evt;
    logic                 w_tick;

    assign w_tick = (r_div == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_stop_evt   = 1'b0;
        if (r_state != StIdle && !w_tick) begin
            w_div_next = r_div - CW'(1);
        end
        case (r_state)
            StIdle: begin
                if (w_fall) begin
                    w_state_next = StStart;
                    w_div_next   = HalfLoad;
                end
            end
            StStart: begin
                if (w_tick) begin
                    if (w_rx_s) begin
                        w_state_next = StIdle;
                    end else begin
                        w_state_next = StData;
                        w_div_next   = FullLoad;
                        w_bit_next   = '0;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    // LSB first: each new bit enters at the top and moves down.
                    w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_div_next   = FullLoad;
                    if (r_bit == LastBit) begin
                        w_state_next = (PARITY != 0) ? StPar : StStop;
                    end else begin
                        w_bit_next = r_bit + 4'd1;
                    end
                end
            end
            StPar: begin
                if (w_tick) begin
                    w_par_next   = w_rx_s;
                    w_div_next   = FullLoad;
                    w_state_next = StStop;
                end
            end
            StStop: begin
                if (w_tick) begin
                    w_stop_evt   = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Word acceptance
    logic w_ones_odd, w_par_ok;
    logic w_frame_set, w_par_set, w_word_ok, w_ovr_set;

    assign w_ones_odd  = (^r_shift) ^ r_par;
    assign w_par_ok    = (PARITY == 0) ? 1'b1 : ((PARITY == 1) ? w_ones_odd : ~w_ones_odd);
    assign w_frame_set = w_stop_evt & ~w_rx_s;
    assign w_par_set   = w_stop_evt & w_rx_s & ~w_par_ok;
    assign w_word_ok   = w_stop_evt & w_rx_s & w_par_ok;

    // FIFO
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wptr, r_rptr;
    logic [CNTW-1:0]      r_count;
    logic                 w_empty, w_full, w_pop, w_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FullCnt);
    assign w_pop     = rx_ready & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign w_push    = w_word_ok & (~w_full | w_pop);
    assign w_ovr_set = w_word_ok & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_data    = w_empty ? '0 : r_mem[r_rptr];
    assign rx_valid   = ~w_empty;
    assign fifo_count = r_count;

    // Sticky error flags
    logic r_frame_err, r_parity_err, r_overrun;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_par_set) begin
                r_parity_err <= 1'b1;
            end else if (clr_err) begin
                r_parity_err <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: two instances (no parity / even parity), CLK_DIV=16,
// FIFO_DEPTH=4. A reference model tracks FIFO occupancy and flags from frame-level
// events; a monitor compares DUT outputs every cycle and pops a scoreboard on handshakes.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CD    = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ser_rx     [2];
    logic       rx_ready   [2];
    logic       clr_err    [2];
    logic [7:0] rx_data    [2];
    logic       rx_valid   [2];
    logic [2:0] fifo_count [2];
    logic       frame_err  [2];
    logic       parity_err [2];
    logic       overrun    [2];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_DIV(CD), .DATA_BITS(DB), .PARITY(0), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .clk(clk), .resetn(resetn), .ser_rx(ser_rx[0]), .rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .fifo_count(fifo_count[0]),
        .frame_err(frame_err[0]), .parity_err(parity_err[0]), .overrun(overrun[0]),
        .clr_err(clr_err[0])
    );

    uart_rx_fifo #(.CLK_DIV(CD), .DATA_BITS(DB), .PARITY(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .resetn(resetn), .ser_rx(ser_rx[1]), .rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .fifo_count(fifo_count[1]),
        .frame_err(frame_err[1]), .parity_err(parity_err[1]), .overrun(overrun[1]),
        .clr_err(clr_err[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    endtask

    // Reference model state
    typedef struct {
        int         d;
        int         s;
        logic [7:0] w;
        bit         stop;
        bit         badp;
    } pend_t;

    pend_t      pend_q [$];
    logic [7:0] eq0 [$];
    logic [7:0] eq1 [$];
    int         cyc = 0;
    int         last_s = 0;
    int         m_cnt [2] = '{0, 0};
    bit         m_fe  [2] = '{0, 0};
    bit         m_pe  [2] = '{0, 0};
    bit         m_ov  [2] = '{0, 0};

    task automatic exp_push(input int d, input logic [7:0] w);
        if (d == 0) eq0.push_back(w);
        else eq1.push_back(w);
    endtask

    task automatic exp_pop(input int d, output logic [7:0] w, output bit ok);
        ok = 1'b0;
        w  = '0;
        if (d == 0 && eq0.size() > 0) begin w = eq0.pop_front(); ok = 1'b1; end
        if (d == 1 && eq1.size() > 0) begin w = eq1.pop_front(); ok = 1'b1; end
    endtask

    // Model: at each clock edge, apply the events of the cycle that just ended.
    initial begin
        bit    pop, push, fe, pe, ov;
        pend_t p;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                pend_q.delete();
                eq0.delete();
                eq1.delete();
                for (int d = 0; d < 2; d++) begin
                    m_cnt[d] = 0; m_fe[d] = 0; m_pe[d] = 0; m_ov[d] = 0;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    pop  = rx_ready[d] && (m_cnt[d] > 0);
                    push = 0; fe = 0; pe = 0; ov = 0;
                    if (pend_q.size() > 0 && pend_q[0].d == d && pend_q[0].s == cyc) begin
                        p = pend_q.pop_front();
                        if (!p.stop) fe = 1;
                        else if (p.badp) pe = 1;
                        else if (m_cnt[d] == DEPTH && !pop) ov = 1;
                        else begin push = 1; exp_push(d, p.w); end
                    end
                    m_cnt[d] = m_cnt[d] + int'(push) - int'(pop);
                    if (fe) m_fe[d] = 1; else if (clr_err[d]) m_fe[d] = 0;
                    if (pe) m_pe[d] = 1; else if (clr_err[d]) m_pe[d] = 0;
                    if (ov) m_ov[d] = 1; else if (clr_err[d]) m_ov[d] = 0;
                end
                cyc++;
            end
        end
    end

    // Monitor
    initial begin
        logic [7:0] w;
        bit         ok;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("count", d, 32'(fifo_count[d]), 32'(m_cnt[d]));
                check("valid", d, 32'(rx_valid[d]), 32'(m_cnt[d] > 0));
                check("flags", d, {29'd0, frame_err[d], parity_err[d], overrun[d]},
                      {29'd0, m_fe[d], m_pe[d], m_ov[d]});
                if (rx_valid[d] && rx_ready[d]) begin
                    exp_pop(d, w, ok);
                    if (ok) check("data", d, 32'(rx_data[d]), 32'(w));
                    else begin
                        n_checks++;
                        $display("FAIL pop_empty dut%0d: popped %0h with no word expected",
                                 d, rx_data[d]);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame; the parity bit (dut1 only) is even parity, flipped when badp.
    task automatic tx(input int d, input logic [7:0] w, input bit stop, input bit badp);
        int n;
        int p;
        @(posedge clk);
        #1;
        n = cyc;
        p = (d == 1) ? 1 : 0;
        // Two synchroniser clocks to T0, half a bit to the start sample.
        last_s = n + 2 + CD / 2 + (DB + p + 1) * CD;
        pend_q.push_back('{d, last_s, w, stop, badp});
        ser_rx[d] = 1'b0;
        wait_cycles(CD);
        for (int k = 0; k < DB; k++) begin
            ser_rx[d] = w[k];
            wait_cycles(CD);
        end
        if (p == 1) begin
            ser_rx[d] = (^w) ^ badp;
            wait_cycles(CD);
        end
        ser_rx[d] = stop;
        wait_cycles(CD);
        ser_rx[d] = 1'b1;
        wait_cycles(2);
    endtask

    // Advances (at +1 after an edge) until the model cycle equals s.
    task automatic wait_until(input int s);
        int k;
        k = 0;
        while (cyc != s && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (cyc == s) n_pass++;
        else $display("FAIL wait_until: reached cycle %0d expected %0d", cyc, s);
    endtask

    task automatic pulse_ready(input int d);
        rx_ready[d] = 1'b1;
        wait_cycles(1);
        rx_ready[d] = 1'b0;
    endtask

    task automatic pulse_clr(input int d);
        clr_err[d] = 1'b1;
        wait_cycles(1);
        clr_err[d] = 1'b0;
    endtask

    bit rand_on;

    initial begin
        int s;
        resetn = 1'b0;
        rand_on = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ser_rx[d] = 1'b1; rx_ready[d] = 1'b0; clr_err[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        wait_cycles(3);

        // Clean frame, including exact rx_valid rise at S+1
        fork
            tx(0, 8'hA5, 1, 0);
            begin
                @(posedge clk);
                #2;
                s = last_s;
                wait_until(s);
                @(negedge clk);
                check("valid_at_S", 0, 32'(rx_valid[0]), 0);
                @(negedge clk);
                check("valid_at_S1", 0, 32'(rx_valid[0]), 1);
            end
        join
        @(negedge clk);
        check("clean_data", 0, 32'(rx_data[0]), 32'h A5);
        check("clean_count", 0, 32'(fifo_count[0]), 1);
        @(posedge clk); #1;
        pulse_ready(0);
        @(negedge clk);
        check("clean_drained", 0, 32'(fifo_count[0]), 0);

        // Even parity: good then bad parity bit
        tx(1, 8'h03, 1, 0);
        tx(1, 8'h03, 1, 1);
        @(negedge clk);
        check("par_err", 1, 32'(parity_err[1]), 1);
        check("par_count", 1, 32'(fifo_count[1]), 1);
        @(posedge clk); #1;
        pulse_clr(1);
        @(negedge clk);
        check("par_cleared", 1, 32'(parity_err[1]), 0);
        @(posedge clk); #1;
        pulse_ready(1);

        // Framing error followed by a clean frame
        tx(0, 8'h55, 0, 0);
        @(negedge clk);
        check("frame_err", 0, 32'(frame_err[0]), 1);
        check("frame_count", 0, 32'(fifo_count[0]), 0);
        tx(0, 8'h12, 1, 0);
        @(negedge clk);
        check("after_frame_data", 0, 32'(rx_data[0]), 32'h12);
        @(posedge clk); #1;
        pulse_clr(0);
        pulse_ready(0);

        // False start glitch
        @(posedge clk); #1;
        ser_rx[0] = 1'b0;
        wait_cycles(4);
        ser_rx[0] = 1'b1;
        wait_cycles(10);
        tx(0, 8'h5A, 1, 0);
        @(negedge clk);
        check("glitch_count", 0, 32'(fifo_count[0]), 1);
        check("glitch_data", 0, 32'(rx_data[0]), 32'h5A);
        @(posedge clk); #1;
        pulse_ready(0);

        // Overrun, drain, pointer wrap
        for (int i = 1; i <= 5; i++) tx(0, 8'(i), 1, 0);
        @(negedge clk);
        check("ovr_count", 0, 32'(fifo_count[0]), 4);
        check("ovr_flag", 0, 32'(overrun[0]), 1);
        @(posedge clk); #1;
        rx_ready[0] = 1'b1;
        wait_cycles(6);
        rx_ready[0] = 1'b0;
        tx(0, 8'h06, 1, 0);
        tx(0, 8'h07, 1, 0);
        rx_ready[0] = 1'b1;
        wait_cycles(3);
        rx_ready[0] = 1'b0;
        pulse_clr(0);
        for (int i = 8; i <= 11; i++) tx(0, 8'(i), 1, 0);
        // Push while full, with a pop in the same cycle
        fork
            tx(0, 8'h0C, 1, 0);
            begin
                @(posedge clk);
                #2;
                s = last_s;
                wait_until(s);
                rx_ready[0] = 1'b1;
                wait_cycles(1);
                rx_ready[0] = 1'b0;
            end
        join
        @(negedge clk);
        check("full_pop_ovr", 0, 32'(overrun[0]), 0);
        check("full_pop_count", 0, 32'(fifo_count[0]), 4);
        check("full_pop_head", 0, 32'(rx_data[0]), 32'h09);
        tx(0, 8'hEE, 1, 0);
        @(negedge clk);
        check("ovr_again", 0, 32'(overrun[0]), 1);

        // Reset during data bit 3
        fork
            tx(0, 8'hFF, 1, 0);
            begin
                @(posedge clk);
                #1;
                wait_cycles(CD * 4 + 8);
                #2;
                resetn = 1'b0;
                #1;
                check("rst_valid", 0, 32'(rx_valid[0]), 0);
                check("rst_count", 0, 32'(fifo_count[0]), 0);
                check("rst_data", 0, 32'(rx_data[0]), 0);
                check("rst_flags", 0, {29'd0, frame_err[0], parity_err[0], overrun[0]}, 0);
                @(posedge clk);
                #1;
                resetn = 1'b1;
            end
        join
        wait_cycles(4);
        tx(0, 8'h3C, 1, 0);
        @(negedge clk);
        check("post_rst_data", 0, 32'(rx_data[0]), 32'h3C);
        check("post_rst_count", 0, 32'(fifo_count[0]), 1);
        @(posedge clk); #1;
        pulse_ready(0);

        // Randomised traffic with random drains and flag clears
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    int         d;
                    logic [7:0] w;
                    d = int'($urandom % 2);
                    w = 8'($urandom);
                    tx(d, w, ($urandom % 8) != 0, (d == 1) && ($urandom % 6 == 0));
                    wait_cycles(int'($urandom % 12));
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    for (int d = 0; d < 2; d++) begin
                        rx_ready[d] = ($urandom % 300 == 0);
                        clr_err[d]  = ($urandom % 300 == 0);
                    end
                    wait_cycles(1);
                end
            end
        join
        for (int d = 0; d < 2; d++) begin
            rx_ready[d] = 1'b1;
            clr_err[d]  = 1'b0;
        end
        wait_cycles(8);
        for (int d = 0; d < 2; d++) rx_ready[d] = 1'b0;
        @(negedge clk);
        check("final_count", 0, 32'(fifo_count[0]), 0);
        check("final_count", 1, 32'(fifo_count[1]), 0);
        check("sb_empty", 0, 32'(eq0.size()), 0);
        check("sb_empty", 1, 32'(eq1.size()), 0);
        wait_cycles(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
